// File: rtl/logger_ev_arb.sv
// logger_ev_arb: round-robin merge of N_REQ event requesters into a single
// registered event stream for the logger packer.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. On the request side, req_ready[w] is high only for the round-robin
// winner w, and only while the output stage is free (load). On the output side,
// ev_* and ev_src stay stable while ev_valid=1 and ev_ready=0.
module logger_ev_arb #(
  parameter  int N_REQ = 2,
  parameter  int ID_W  = 16,
  parameter  int TS_W  = 64,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*ID_W-1:0] req_id,
  input  logic [N_REQ*TS_W-1:0] req_start,
  input  logic [N_REQ*TS_W-1:0] req_end,
  input  logic [N_REQ*TS_W-1:0] req_delta,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [ID_W-1:0]       ev_id,
  output logic [TS_W-1:0]       ev_start,
  output logic [TS_W-1:0]       ev_end,
  output logic [TS_W-1:0]       ev_delta,
  output logic [SRC_W-1:0]      ev_src
);

  // Output stage and round-robin pointer
  logic             ev_valid_q, ev_valid_d;
  logic [ID_W-1:0]  ev_id_q,    ev_id_d;
  logic [TS_W-1:0]  ev_start_q, ev_start_d;
  logic [TS_W-1:0]  ev_end_q,   ev_end_d;
  logic [TS_W-1:0]  ev_delta_q, ev_delta_d;
  logic [SRC_W-1:0] ev_src_q,   ev_src_d;
  logic [SRC_W-1:0] rr_ptr_q,   rr_ptr_d;

  // Arbitration results
  logic             load;
  logic             found;
  logic [SRC_W-1:0] win;

  // Output stage can take a new event when empty or draining this cycle
  assign load = ~ev_valid_q | ev_ready;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin : arb_search
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = SRC_W'(idx);
      end
    end
  end

  // Grant, payload capture and pointer advance; nothing is granted during reset
  always_comb begin
    req_ready  = '0;
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    ev_start_d = ev_start_q;
    ev_end_d   = ev_end_q;
    ev_delta_d = ev_delta_q;
    ev_src_d   = ev_src_q;
    rr_ptr_d   = rr_ptr_q;
    if (!rst && load) begin
      if (found) begin
        req_ready[win] = 1'b1;
        ev_valid_d     = 1'b1;
        ev_id_d        = req_id[int'(win)*ID_W +: ID_W];
        ev_start_d     = req_start[int'(win)*TS_W +: TS_W];
        ev_end_d       = req_end[int'(win)*TS_W +: TS_W];
        ev_delta_d     = req_delta[int'(win)*TS_W +: TS_W];
        ev_src_d       = win;
        rr_ptr_d       = SRC_W'((int'(win) + 1) % N_REQ);
      end else begin
        // Payload left stale but stable; only the valid flag drops
        ev_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; a held event is simply discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ev_start_q <= '0;
      ev_end_q   <= '0;
      ev_delta_q <= '0;
      ev_src_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      ev_start_q <= ev_start_d;
      ev_end_q   <= ev_end_d;
      ev_delta_q <= ev_delta_d;
      ev_src_q   <= ev_src_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign ev_start = ev_start_q;
  assign ev_end   = ev_end_q;
  assign ev_delta = ev_delta_q;
  assign ev_src   = ev_src_q;

endmodule

// File: tb/tb_logger_ev_arb.sv
// tb_logger_ev_arb: directed scenarios plus a randomized run against a
// behavioural round-robin model and a per-source ordering scoreboard.
module tb_logger_ev_arb;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int TW = 64;
  localparam int SW = 2;
  localparam int PW = SW + IW + 3 * TW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_id;
  logic [N*TW-1:0] req_start, req_end, req_delta;
  logic            ev_valid, ev_ready;
  logic [IW-1:0]   ev_id;
  logic [TW-1:0]   ev_start, ev_end, ev_delta;
  logic [SW-1:0]   ev_src;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] exp_q[$];

  logger_ev_arb #(.N_REQ(N), .ID_W(IW), .TS_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_start (req_start),
    .req_end   (req_end),
    .req_delta (req_delta),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_id     (ev_id),
    .ev_start  (ev_start),
    .ev_end    (ev_end),
    .ev_delta  (ev_delta),
    .ev_src    (ev_src)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge; returns just after a falling edge with rst low
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    ev_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic set_req(input int i, input logic [IW-1:0] id, input logic [TW-1:0] s,
                         input logic [TW-1:0] e, input logic [TW-1:0] d);
    req_id[i*IW +: IW]    = id;
    req_start[i*TW +: TW] = s;
    req_end[i*TW +: TW]   = e;
    req_delta[i*TW +: TW] = d;
  endtask

  function automatic logic [PW-1:0] req_pack(input int i);
    return {SW'(i), req_id[i*IW +: IW], req_start[i*TW +: TW], req_end[i*TW +: TW],
            req_delta[i*TW +: TW]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    req_valid = '1;
    ev_ready  = 1'b1;
    #1;
    if (req_ready !== 4'b0000) begin
      $display("FAIL reset_ready: got %b want 0000", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if ({ev_valid, ev_src} !== 3'b000) begin
      $display("FAIL reset_valid_src: got v=%b src=%0d want 0/0", ev_valid, ev_src); n_fail++;
    end
    n_checks++;
    if ({ev_id, ev_start, ev_end, ev_delta} !== '0) begin
      $display("FAIL reset_payload: got id=%h start=%h end=%h delta=%h want 0",
               ev_id, ev_start, ev_end, ev_delta); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    set_req(0, 16'h1234, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'h0000_0000_0000_0fed);
    req_valid = 4'b0001;
    ev_ready  = 1'b1;
    #1;
    if (req_ready !== 4'b0001) begin
      $display("FAIL single_ready: got %b want 0001", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (ev_valid !== 1'b1 || ev_id !== 16'h1234 || ev_src !== 2'd0) begin
      $display("FAIL single_out: got v=%b id=%h src=%0d want 1/1234/0", ev_valid, ev_id, ev_src); n_fail++;
    end
    n_checks++;
    if (ev_start !== 64'h1111_0000_0000_0001 || ev_end !== 64'h2222_0000_0000_0002 ||
        ev_delta !== 64'h0000_0000_0000_0fed) begin
      $display("FAIL single_ts: got start=%h end=%h delta=%h", ev_start, ev_end, ev_delta); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    if (ev_valid !== 1'b0 || ev_id !== 16'h1234) begin
      $display("FAIL single_idle: got v=%b id=%h want 0/1234 (stale)", ev_valid, ev_id); n_fail++;
    end
    n_checks++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 16'h0100, 64'd10, 64'd11, 64'd1);
    set_req(1, 16'h0101, 64'd20, 64'd21, 64'd1);
    req_valid = 4'b0011;
    ev_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (req_ready !== 4'(1 << (c % 2))) begin
        $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 2))); n_fail++;
      end
      n_checks++;
      @(posedge clk); #1;
      if (ev_valid !== 1'b1 || ev_src !== SW'(c % 2) || ev_id !== 16'(16'h0100 + c % 2)) begin
        $display("FAIL rr_out[%0d]: got v=%b src=%0d id=%h want 1/%0d", c, ev_valid, ev_src, ev_id, c % 2);
        n_fail++;
      end
      n_checks++;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 16'hAAAA, 64'hA0, 64'hA1, 64'h1);
    req_valid = 4'b0001;
    ev_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req(1, 16'hBBBB, 64'hB0, 64'hB1, 64'h1);
    req_valid = 4'b0010;
    ev_ready  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); n_fail++;
      end
      n_checks++;
      @(posedge clk); #1;
      if (ev_valid !== 1'b1 || ev_id !== 16'hAAAA || ev_src !== 2'd0 || ev_start !== 64'hA0) begin
        $display("FAIL bp_hold[%0d]: got v=%b id=%h src=%0d start=%h want 1/aaaa/0/a0",
                 c, ev_valid, ev_id, ev_src, ev_start); n_fail++;
      end
      n_checks++;
      @(negedge clk);
    end
    ev_ready = 1'b1;
    #1;
    if (req_ready !== 4'b0010) begin
      $display("FAIL bp_release_ready: got %b want 0010", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (ev_valid !== 1'b1 || ev_id !== 16'hBBBB || ev_src !== 2'd1) begin
      $display("FAIL bp_release_out: got v=%b id=%h src=%0d want 1/bbbb/1", ev_valid, ev_id, ev_src);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(2, 16'h2222, 64'd2, 64'd2, 64'd0);
    set_req(3, 16'h3333, 64'd3, 64'd3, 64'd0);
    set_req(0, 16'h0A0A, 64'd4, 64'd4, 64'd0);
    set_req(1, 16'h1B1B, 64'd5, 64'd5, 64'd0);
    req_valid = 4'b0100;
    ev_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    if (req_ready !== 4'b1000) begin
      $display("FAIL wrap_ready3: got %b want 1000", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (ev_src !== 2'd3 || ev_id !== 16'h3333) begin
      $display("FAIL wrap_out3: got src=%0d id=%h want 3/3333", ev_src, ev_id); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    if (req_ready !== 4'b0001) begin
      $display("FAIL wrap_ready0: got %b want 0001", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (ev_src !== 2'd0 || ev_id !== 16'h0A0A) begin
      $display("FAIL wrap_out0: got src=%0d id=%h want 0/0a0a", ev_src, ev_id); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    if (req_ready !== 4'b0010) begin
      $display("FAIL wrap_ptr1: got %b want 0010", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 16'h5555, 64'd55, 64'd56, 64'd1);
    req_valid = 4'b0001;
    ev_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    ev_ready  = 1'b0;
    @(posedge clk); #1;
    if (ev_valid !== 1'b1 || ev_id !== 16'h5555) begin
      $display("FAIL rmid_held: got v=%b id=%h want 1/5555", ev_valid, ev_id); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    if (req_ready !== 4'b0000) begin
      $display("FAIL rmid_ready: got %b want 0000", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (ev_valid !== 1'b0 || ev_id !== 16'h0000 || ev_src !== 2'd0) begin
      $display("FAIL rmid_cleared: got v=%b id=%h src=%0d want 0/0000/0", ev_valid, ev_id, ev_src);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    rst      = 1'b0;
    ev_ready = 1'b1;
    #1;
    if (req_ready !== 4'b0001) begin
      $display("FAIL rmid_first_ready: got %b want 0001", req_ready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    if (ev_valid !== 1'b1 || ev_src !== 2'd0) begin
      $display("FAIL rmid_first_out: got v=%b src=%0d want 1/0", ev_valid, ev_src); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    req_valid = '0;
  endtask

  // Random traffic against a behavioural model; the scoreboard checks each
  // accepted request leaves exactly once, in per-source order.
  task automatic test_random();
    bit            pend[N];
    int            waits[N];
    int            max_wait;
    int            grants;
    bit            m_valid;
    logic [PW-1:0] m_pay;
    int            m_next;
    int            exp_w;
    bit            load;
    logic [N-1:0]  exp_rdy;
    int            hit;
    logic [PW-1:0] got;
    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 0; waits[i] = 0; end
    max_wait = 0; grants = 0;
    m_valid = 0; m_pay = '0; m_next = 0;
    exp_q.delete();
    for (int c = 0; c < 10010; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c >= 10000) pend[i] = 0;
        else if (pend[i]) begin
          if ($urandom_range(0, 9) == 0) begin pend[i] = 0; waits[i] = 0; end
        end else if ($urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          set_req(i, 16'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end
        req_valid[i] = pend[i];
      end
      ev_ready = (c >= 10000) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #1;
      // Expected winner: highest-priority pending requester, priority rotating past the last winner
      load  = !m_valid || ev_ready;
      exp_w = -1;
      if (load) begin
        for (int k = N - 1; k >= 0; k--)
          if (pend[(m_next + k) % N]) exp_w = (m_next + k) % N;
      end
      exp_rdy = (exp_w >= 0) ? 4'(1 << exp_w) : 4'b0000;
      if (req_ready !== exp_rdy) begin
        $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); n_fail++;
      end
      n_checks++;
      // Output handoff: match against oldest queued event from that source
      if (m_valid && ev_ready) begin
        got = {ev_src, ev_id, ev_start, ev_end, ev_delta};
        hit = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (hit < 0 && exp_q[j][PW-1 -: SW] == ev_src) hit = j;
        if (hit < 0) begin
          $display("FAIL rand_sb_unexpected[%0d]: got %h with nothing queued", c, got); n_fail++;
        end else begin
          if (got !== exp_q[hit]) begin
            $display("FAIL rand_sb_data[%0d]: got %h want %h", c, got, exp_q[hit]); n_fail++;
          end
          exp_q.delete(hit);
        end
        n_checks++;
      end
      if (exp_w >= 0) begin
        exp_q.push_back(req_pack(exp_w));
        grants++;
        for (int i = 0; i < N; i++) begin
          if (i == exp_w) waits[i] = 0;
          else if (pend[i]) begin
            waits[i]++;
            if (waits[i] > max_wait) max_wait = waits[i];
          end
        end
        m_valid = 1; m_pay = req_pack(exp_w); m_next = (exp_w + 1) % N;
        pend[exp_w] = 0;
      end else if (load) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
      if (ev_valid !== m_valid || (m_valid && {ev_src, ev_id, ev_start, ev_end, ev_delta} !== m_pay)) begin
        $display("FAIL rand_out[%0d]: got v=%b src=%0d id=%h want v=%b pay=%h",
                 c, ev_valid, ev_src, ev_id, m_valid, m_pay); n_fail++;
      end
      n_checks++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || grants < 1000) begin
      $display("FAIL rand_drain: got %0d leftover, %0d grants want 0 leftover, >=1000 grants",
               exp_q.size(), grants); n_fail++;
    end
    n_checks++;
    if (max_wait > N - 1) begin
      $display("FAIL rand_starvation: got max wait %0d grants want <= %0d", max_wait, N - 1); n_fail++;
    end
    n_checks++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    ev_ready  = 1'b0;
    req_id    = '0;
    req_start = '0;
    req_end   = '0;
    req_delta = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logger_ev_arb.md
LOGGER_EV_ARB -- requirements
Module: logger_ev_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of event requesters (range 2..8).
REQ-002 SHALL have parameter ID_W, default 16, event ID width.
REQ-003 SHALL have parameter TS_W, default 64, timestamp and delta width.
REQ-004 SHALL derive localparam SRC_W = max(1, clog2(N_REQ)), the source index width.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port req_valid, input, N_REQ, per-requester event valid.
REQ-008 SHALL have port req_ready, output, N_REQ, per-requester accept.
REQ-009 SHALL have port req_id, input, N_REQ*ID_W, flattened IDs; requester i at [i*ID_W +: ID_W].
REQ-010 SHALL have ports req_start, req_end and req_delta, each input, N_REQ*TS_W, flattened the same way.
REQ-011 SHALL have port ev_valid, output, 1, merged event valid to the logger packer.
REQ-012 SHALL have port ev_ready, input, 1, packer accept.
REQ-013 SHALL have ports ev_id (ID_W), ev_start, ev_end and ev_delta (TS_W each), all outputs, carrying the granted payload.
REQ-014 SHALL have port ev_src, output, SRC_W, index of the requester that supplied the current ev_* payload.

Function
REQ-015 SHALL hold the ev_* and ev_src outputs in a single registered output stage; no combinational path from req_* to ev_*.
REQ-016 SHALL define load = ~ev_valid | ev_ready, meaning the output stage is free in this cycle.
REQ-017 SHALL arbitrate round-robin: search req_valid starting at index rr_ptr, ascending with wrap modulo N_REQ; the first set bit wins.
REQ-018 SHALL assert req_ready[w] for the winner w only, combinationally, and only when load=1 and req_valid[w]=1; all other req_ready bits SHALL be 0.
REQ-019 SHALL, on a cycle with a winner, register that requester's payload into ev_*, set ev_src=w and ev_valid=1 at the next edge, and set rr_ptr to (w+1) mod N_REQ.
REQ-020 SHALL, when load=1 and no req_valid bit is set, clear ev_valid at the next edge and leave rr_ptr unchanged.
REQ-021 SHALL, while ev_valid=1 and ev_ready=0, hold all ev_* and ev_src stable, drive req_ready to all zeros, and leave rr_ptr unchanged.
REQ-022 SHALL give a latency of exactly 1 cycle from the req handshake to ev_valid, and a throughput of 1 event per cycle when ev_ready is held high.
REQ-023 SHALL require requesters to hold req_valid and payload stable until req_ready; a requester dropping req_valid before its grant is permitted and simply loses arbitration.
REQ-024 SHALL accept a new event in the same cycle the output stage hands off (ev_valid & ev_ready), giving no bubble.
REQ-025 SHALL ensure no requester waits more than N_REQ-1 other grants once its req_valid is high (starvation-free).
REQ-026 SHALL keep ev_* values undefined-safe: registers update only on a grant, so data is stale but stable when ev_valid=0.

Reset
REQ-027 SHALL, while rst=1, drive ev_valid=0, req_ready=0, rr_ptr=0, ev_src=0, and ev_id/ev_start/ev_end/ev_delta=0.
REQ-028 SHALL, when rst is asserted mid-transfer, discard the held event with no handshake, and grant nothing in the rst cycle.
REQ-029 SHALL allow the first grant on the first cycle with rst=0, i.e. visible as ev_valid on the following edge.

Verification
REQ-030 SHALL cover a single requester: N_REQ=2, req_valid=01, req_id[0]=0x1234, ev_ready=1 -> req_ready=01 at t, then ev_valid=1, ev_id=0x1234, ev_src=0 at t+1.
REQ-031 SHALL cover round-robin fairness: req_valid=11 held with ev_ready=1 for 4 cycles -> ev_src sequence 0,1,0,1 with no idle cycles.
REQ-032 SHALL cover backpressure: ev_ready=0 for 5 cycles with ev_valid=1 and ev_id=0xAAAA -> ev_* stable, req_ready=00; ev_ready=1 -> next queued event appears 1 cycle later.
REQ-033 SHALL cover wrap-around: N_REQ=4, rr_ptr=3, req_valid=1001 -> grant index 3, then index 0, then rr_ptr=1.
REQ-034 SHALL cover reset mid-operation: rst=1 while ev_valid=1 and ev_ready=0 -> next cycle ev_valid=0, req_ready=0000, and after release the first grant goes to index 0.
REQ-035 SHALL cover the integrity check: random valid/ready on all ports for 10k cycles -> every accepted req appears exactly once on ev_* with matching ev_src, in per-source order.
